// File: rtl/sram_stream_fifo.sv
// Stream FIFO controller around a 1W/1R SRAM with 1-cycle registered read.
// A 2-entry output buffer hides the read latency so output runs at one beat per cycle.
module sram_stream_fifo #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_count_q, ob_count_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic       wr_accept;
  logic       pop;
  logic       rd_issue;
  logic [2:0] ob_pending;

  // Handshake and strobe generation
  always_comb begin
    s_ready     = rst_n && (ram_count_q != FULL_COUNT);
    wr_accept   = s_valid && s_ready;
    m_valid     = (ob_count_q != 2'd0);
    m_data      = ob0_q;
    pop         = m_valid && m_ready;
    // Buffer slots already claimed after this cycle's pop; a read is issued only if one stays free.
    ob_pending  = {1'b0, ob_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue    = (ram_count_q != '0) && (ob_pending < 3'd2);

    ram_wr_en   = wr_accept;
    ram_wr_addr = wr_ptr_q;
    ram_wr_data = s_data;
    ram_rd_en   = rd_issue;
    ram_rd_addr = rd_ptr_q;

    count = (ADDR_WIDTH + 2)'(ram_count_q)
          + (ADDR_WIDTH + 2)'(inflight_q)
          + (ADDR_WIDTH + 2)'(ob_count_q);
  end

  // Pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    inflight_d  = rd_issue;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    ram_count_d = ram_count_q
                + (ADDR_WIDTH + 1)'(wr_accept)
                - (ADDR_WIDTH + 1)'(rd_issue);
  end

  // Output buffer: pop shifts first, then the returning read fills the next free slot
  always_comb begin
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    ob_count_d = ob_count_q;

    if (pop) begin
      ob0_d      = ob1_q;
      ob_count_d = ob_count_q - 2'd1;
    end
    if (inflight_q) begin
      if (ob_count_d == 2'd0) begin
        ob0_d = ram_rd_data;
      end else begin
        ob1_d = ram_rd_data;
      end
      ob_count_d = ob_count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      ob_count_q  <= '0;
      ob0_q       <= '0;
      ob1_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      ob_count_q  <= ob_count_d;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
    end
  end

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Bench for sram_stream_fifo: behavioural SRAM, queue-based reference model,
// a short vector table for single-beat latency, and directed/random sequences.
module tb_sram_stream_fifo;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] count;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  sram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256x32 SRAM, registered read
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // Reference model
  logic [DW-1:0] model_q[$];
  int unsigned   wr_total;
  int unsigned   rd_total;
  int unsigned   pop_total;
  logic          last_accept;
  logic          last_pop;
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    wr_total  = 0;
    rd_total  = 0;
    pop_total = 0;
    prev_hold = 1'b0;
    prev_data = '0;
  endtask

  // One cycle: drive at negedge, sample 1 time unit later, check and update the model
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    check("count", 64'(count), 64'(model_q.size()));
    check("wr_en", 64'(ram_wr_en), 64'(sv && s_ready));
    if (model_q.size() < DEPTH)     check("s_ready_not_full", 64'(s_ready), 64'(1));
    if (model_q.size() == DEPTH + 2) check("s_ready_full", 64'(s_ready), 64'(0));
    if (model_q.size() == 0)        check("m_valid_empty", 64'(m_valid), 64'(0));
    if (ram_wr_en) check("wr_addr", 64'(ram_wr_addr), 64'(wr_total % DEPTH));
    if (ram_rd_en) check("rd_addr", 64'(ram_rd_addr), 64'(rd_total % DEPTH));
    if (ram_wr_en && ram_rd_en) check("rw_addr_differ", 64'(ram_rd_addr != ram_wr_addr), 64'(1));
    if (prev_hold) begin
      check("m_valid_hold", 64'(m_valid), 64'(1));
      check("m_data_stable", 64'(m_data), 64'(prev_data));
    end
    last_pop    = m_valid && m_ready;
    last_accept = sv && s_ready;
    if (last_pop) begin
      if (model_q.size() == 0) check("pop_on_empty", 64'(m_valid), 64'(0));
      else                     check("m_data", 64'(m_data), 64'(model_q.pop_front()));
      pop_total++;
    end
    if (last_accept) begin
      model_q.push_back(sd);
      wr_total++;
    end
    if (ram_rd_en) rd_total++;
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b0;
    #1;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_wr_en", 64'(ram_wr_en), 64'(0));
    check("rst_rd_en", 64'(ram_rd_en), 64'(0));
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_wr;
    logic          e_rd;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic [AW+1:0] e_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int unsigned n;
    int unsigned cyc;
    logic        got;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    m_ready     = 1'b0;
    model_clear();

    // Single-beat latency table
    vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         10'd0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         10'd1};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         10'd1};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 10'd1};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         10'd0};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].sv, vecs[i].sd, vecs[i].mr);
      check($sformatf("t1_wr_en[%0d]", i), 64'(ram_wr_en), 64'(vecs[i].e_wr));
      check($sformatf("t1_rd_en[%0d]", i), 64'(ram_rd_en), 64'(vecs[i].e_rd));
      check($sformatf("t1_m_valid[%0d]", i), 64'(m_valid), 64'(vecs[i].e_mv));
      if (vecs[i].e_mv) check($sformatf("t1_m_data[%0d]", i), 64'(m_data), 64'(vecs[i].e_md));
      check($sformatf("t1_count[%0d]", i), 64'(count), 64'(vecs[i].e_cnt));
    end

    // Fill with downstream stalled, then drain back-to-back
    do_reset();
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, DW'(acc), 1'b0);
      if (last_accept) acc++;
      if (i >= 280) begin
        check("t2_s_ready_full", 64'(s_ready), 64'(0));
        check("t2_rd_en_stall", 64'(ram_rd_en), 64'(0));
        check("t2_count", 64'(count), 64'(258));
      end
    end
    check("t2_accepted", 64'(acc), 64'(258));
    for (int i = 0; i < 258; i++) begin
      step(1'b0, '0, 1'b1);
      check("t2_drain_no_bubble", 64'(m_valid), 64'(1));
    end
    step(1'b0, '0, 1'b1);
    check("t2_drained", 64'(count), 64'(0));

    // Continuous streaming through pointer wrap
    do_reset();
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 1100) begin
      step(1'b1, DW'(n), 1'b1);
      if (last_accept) n++;
      if (cyc >= 3) check("t3_no_bubble", 64'(m_valid), 64'(1));
      check("t3_s_ready", 64'(s_ready), 64'(1));
      cyc++;
    end
    check("t3_accepted", 64'(n), 64'(1000));
    cyc = 0;
    while (model_q.size() != 0 && cyc < 10) begin
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    step(1'b0, '0, 1'b1);
    check("t3_drained", 64'(count), 64'(0));

    // Random traffic against the scoreboard
    do_reset();
    cyc = 0;
    while (pop_total < 10000 && cyc < 60000) begin
      step(1'($urandom % 2), $urandom, 1'($urandom % 2));
      cyc++;
    end
    check("t4_pops", 64'(pop_total >= 10000), 64'(1));
    cyc = 0;
    while (model_q.size() != 0 && cyc < 600) begin
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    step(1'b0, '0, 1'b1);
    check("t4_drained", 64'(count), 64'(0));

    // Asynchronous reset with beats held
    do_reset();
    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 200) begin
      step(1'b1, DW'(32'hBEEF_0000 + acc), 1'b0);
      if (last_accept) acc++;
      cyc++;
    end
    step(1'b0, '0, 1'b0);
    check("t5_count_before", 64'(count), 64'(100));
    check("t5_m_valid_before", 64'(m_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_valid", 64'(m_valid), 64'(0));
    check("t5_rst_count", 64'(count), 64'(0));
    check("t5_rst_s_ready", 64'(s_ready), 64'(0));
    check("t5_rst_rd_en", 64'(ram_rd_en), 64'(0));
    check("t5_rst_wr_en", 64'(ram_wr_en), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step(1'b1, 32'h0000_1234, 1'b1);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 8) begin
      step(1'b0, '0, 1'b1);
      got = last_pop;
      cyc++;
    end
    check("t5_fresh_beat_out", 64'(got), 64'(1));
    check("t5_pop_count", 64'(pop_total), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
